// File: rtl/block_transfer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : block_transfer_sequencer_pkg
// Description : Shared types, constants and helpers for the LDM/STM sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package block_transfer_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_WBACK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] PC_REG     = 4'd15;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_transfer_sequencer_lowest_set_finder.sv
`default_nettype none
// ============================================================================
// Module      : lowest_set_finder
// Description : 16-bit priority encoder returning the index of the lowest set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module lowest_set_finder (
    input  logic [15:0] i_mask,
    output logic [3:0]  o_index,
    output logic        o_valid
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        o_index = '0;
        for (int i = 15; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_index = 4'(i);
            end
        end
    end

    assign o_valid = |i_mask;

endmodule
`default_nettype wire

// File: rtl/block_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : block_transfer_sequencer
// Description : Load/store-multiple sequencer driving register file and memory.
// Revision    : 1.0 - initial release
// ============================================================================
module block_transfer_sequencer
    import block_transfer_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             L,
    input  logic             U,
    input  logic             P,
    input  logic             W,
    input  logic [3:0]       Rn,
    input  logic [NREGS-1:0] RegList,
    input  logic [WIDTH-1:0] BaseVal,
    input  logic [WIDTH-1:0] RegRD,
    input  logic [WIDTH-1:0] MemRD,
    input  logic             MemReady,
    output logic [3:0]       RegRAddr,
    output logic [3:0]       RegWAddr,
    output logic             RegWE,
    output logic [WIDTH-1:0] RegWD,
    output logic             PCWE,
    output logic             MemReq,
    output logic             MemWE,
    output logic [WIDTH-1:0] MemAddr,
    output logic [WIDTH-1:0] MemWD,
    output logic             Busy,
    output logic             Done
);

    localparam logic [WIDTH-1:0] c_word = WIDTH'(WORD_BYTES);

    state_t             r_state;
    logic               r_l;
    logic               r_w;
    logic               r_rn_in_list;
    logic [3:0]         r_rn;
    logic [NREGS-1:0]   r_mask;
    logic [WIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]   r_final;

    logic [4:0]         w_cnt;
    logic [WIDTH-1:0]   w_span;
    logic [WIDTH-1:0]   w_start_addr;
    logic [3:0]         w_idx;
    logic               w_valid;
    logic [NREGS-1:0]   w_mask_next;
    logic               w_load_beat;

    lowest_set_finder u_finder (
        .i_mask  (r_mask),
        .o_index (w_idx),
        .o_valid (w_valid)
    );

    assign w_cnt       = popcount16(RegList);
    assign w_span      = WIDTH'(w_cnt) * c_word;
    assign w_mask_next = r_mask & ~(NREGS'(1) << w_idx);

    // Decrementing modes still walk upward from the lowest address of the block.
    always_comb begin
        w_start_addr = BaseVal;
        case ({U, P})
            2'b10:   w_start_addr = BaseVal;
            2'b11:   w_start_addr = BaseVal + c_word;
            2'b00:   w_start_addr = BaseVal - w_span + c_word;
            default: w_start_addr = BaseVal - w_span;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_l          <= 1'b0;
            r_w          <= 1'b0;
            r_rn_in_list <= 1'b0;
            r_rn         <= '0;
            r_mask       <= '0;
            r_addr       <= '0;
            r_final      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_l          <= L;
                        r_w          <= W;
                        r_rn         <= Rn;
                        r_rn_in_list <= RegList[Rn];
                        r_mask       <= RegList;
                        r_addr       <= w_start_addr;
                        r_final      <= U ? (BaseVal + w_span) : (BaseVal - w_span);
                        r_state      <= (w_cnt != 5'd0) ? ST_XFER : ST_DONE;
                    end
                end
                ST_XFER: begin
                    if (MemReady && w_valid) begin
                        r_mask <= w_mask_next;
                        r_addr <= r_addr + c_word;
                        if (w_mask_next == '0) begin
                            // A load that refills Rn keeps the loaded value instead.
                            r_state <= (r_w && !(r_l && r_rn_in_list)) ? ST_WBACK : ST_DONE;
                        end
                    end
                end
                ST_WBACK: r_state <= ST_DONE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_load_beat = (r_state == ST_XFER) && r_l && MemReady && w_valid;

    always_comb begin
        RegRAddr = '0;
        RegWAddr = '0;
        RegWE    = 1'b0;
        RegWD    = '0;
        PCWE     = 1'b0;
        MemReq   = 1'b0;
        MemWE    = 1'b0;
        MemAddr  = '0;
        MemWD    = '0;
        Busy     = (r_state != ST_IDLE);
        Done     = (r_state == ST_DONE);
        if (r_state == ST_XFER) begin
            MemReq  = 1'b1;
            MemAddr = r_addr;
            if (!r_l) begin
                RegRAddr = w_idx;
                MemWE    = 1'b1;
                MemWD    = RegRD;
            end
        end
        if (w_load_beat) begin
            RegWAddr = w_idx;
            RegWD    = MemRD;
            PCWE     = (w_idx == PC_REG);
            RegWE    = (w_idx != PC_REG);
        end
        if (r_state == ST_WBACK) begin
            RegWE    = 1'b1;
            RegWAddr = r_rn;
            RegWD    = r_final;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_block_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_transfer_sequencer
// Description : Directed self-checking bench for block_transfer_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_transfer_sequencer;

    logic        CLK = 1'b0;
    logic        RST, Start, L, U, P, W, MemReady;
    logic [3:0]  Rn;
    logic [15:0] RegList;
    logic [31:0] BaseVal, RegRD, MemRD;
    logic [3:0]  RegRAddr, RegWAddr;
    logic        RegWE, PCWE, MemReq, MemWE, Busy, Done;
    logic [31:0] RegWD, MemAddr, MemWD;

    logic [31:0] regs [16];
    int total = 0;
    int bad   = 0;

    block_transfer_sequencer #(.WIDTH(32), .NREGS(16)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .L(L), .U(U), .P(P), .W(W),
        .Rn(Rn), .RegList(RegList), .BaseVal(BaseVal), .RegRD(RegRD),
        .MemRD(MemRD), .MemReady(MemReady), .RegRAddr(RegRAddr),
        .RegWAddr(RegWAddr), .RegWE(RegWE), .RegWD(RegWD), .PCWE(PCWE),
        .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWD(MemWD),
        .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    assign RegRD = regs[RegRAddr];

    always @(posedge CLK) begin
        if (RegWE) regs[RegWAddr] <= RegWD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic adv;
        @(posedge CLK);
        #1;
    endtask

    task automatic launch(input logic l, input logic u, input logic p, input logic w,
                          input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base);
        Start = 1'b1; L = l; U = u; P = p; W = w; Rn = rn; RegList = list; BaseVal = base;
        adv();
        Start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'h1000 + i;
        RST = 1'b1; Start = 1'b0; L = 0; U = 0; P = 0; W = 0; Rn = 0;
        RegList = 0; BaseVal = 0; MemRD = 0; MemReady = 1'b1;
        adv(); adv();
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_memreq", MemReq, 0);
        chk("rst_regwe", RegWE, 0);
        chk("rst_done", Done, 0);
        RST = 1'b0;
        adv();

        // STMIA R0!,{R1,R2,R4}
        launch(0, 1, 0, 1, 4'd0, 16'h0016, 32'h100);
        #1;
        chk("t1_c1_addr", MemAddr, 32'h100); chk("t1_c1_we", MemWE, 1);
        chk("t1_c1_wd", MemWD, 32'h1001);    chk("t1_c1_busy", Busy, 1);
        adv(); #1;
        chk("t1_c2_addr", MemAddr, 32'h104); chk("t1_c2_wd", MemWD, 32'h1002);
        adv(); #1;
        chk("t1_c3_addr", MemAddr, 32'h108); chk("t1_c3_wd", MemWD, 32'h1004);
        chk("t1_c3_regwe", RegWE, 0);
        adv(); #1;
        chk("t1_wb_we", RegWE, 1); chk("t1_wb_addr", RegWAddr, 0);
        chk("t1_wb_wd", RegWD, 32'h10C); chk("t1_wb_memreq", MemReq, 0);
        adv(); #1;
        chk("t1_done", Done, 1);
        adv(); #1;
        chk("t1_idle_busy", Busy, 0); chk("t1_r0", regs[0], 32'h10C);

        // LDMDB R13!,{R4,R5}
        MemRD = 32'hAA;
        launch(1, 0, 1, 1, 4'd13, 16'h0030, 32'h200);
        #1;
        chk("t2_c1_addr", MemAddr, 32'h1F8); chk("t2_c1_memwe", MemWE, 0);
        chk("t2_c1_we", RegWE, 1); chk("t2_c1_wa", RegWAddr, 4);
        chk("t2_c1_wd", RegWD, 32'hAA);
        adv(); MemRD = 32'hBB; #1;
        chk("t2_c2_addr", MemAddr, 32'h1FC); chk("t2_c2_wa", RegWAddr, 5);
        chk("t2_c2_wd", RegWD, 32'hBB);
        adv(); #1;
        chk("t2_wb_wa", RegWAddr, 13); chk("t2_wb_wd", RegWD, 32'h1F8);
        chk("t2_wb_we", RegWE, 1);
        adv(); #1;
        chk("t2_done", Done, 1);
        adv(); #1;
        chk("t2_r4", regs[4], 32'hAA); chk("t2_r5", regs[5], 32'hBB);

        // LDMIB R1,{R3} with two wait cycles
        MemReady = 1'b0; MemRD = 32'h33;
        launch(1, 1, 1, 0, 4'd1, 16'h0008, 32'h300);
        #1;
        chk("t3_c1_addr", MemAddr, 32'h304); chk("t3_c1_we", RegWE, 0);
        chk("t3_c1_req", MemReq, 1);
        adv(); #1;
        chk("t3_c2_addr", MemAddr, 32'h304); chk("t3_c2_we", RegWE, 0);
        adv(); MemReady = 1'b1; #1;
        chk("t3_c3_addr", MemAddr, 32'h304); chk("t3_c3_we", RegWE, 1);
        chk("t3_c3_wa", RegWAddr, 3); chk("t3_c3_wd", RegWD, 32'h33);
        adv(); #1;
        chk("t3_done", Done, 1); chk("t3_nowb", RegWE, 0);
        adv();

        // LDMIA R2!,{R2,R3}: base writeback suppressed
        MemRD = 32'h55;
        launch(1, 1, 0, 1, 4'd2, 16'h000C, 32'h400);
        #1;
        chk("t4_c1_addr", MemAddr, 32'h400); chk("t4_c1_wa", RegWAddr, 2);
        chk("t4_c1_wd", RegWD, 32'h55);
        adv(); MemRD = 32'h66; #1;
        chk("t4_c2_addr", MemAddr, 32'h404); chk("t4_c2_wa", RegWAddr, 3);
        adv(); #1;
        chk("t4_done", Done, 1); chk("t4_nowb", RegWE, 0);
        adv(); #1;
        chk("t4_r2", regs[2], 32'h55); chk("t4_r3", regs[3], 32'h66);

        // Empty list with writeback requested
        launch(0, 1, 0, 1, 4'd6, 16'h0000, 32'h700);
        #1;
        chk("t5_done", Done, 1); chk("t5_req", MemReq, 0);
        chk("t5_we", RegWE, 0); chk("t5_pcwe", PCWE, 0);
        adv(); #1;
        chk("t5_idle", Busy, 0); chk("t5_r6", regs[6], 32'h1006);

        // STMDA R5!,{R4-R7} aborted by reset in cycle 2
        launch(0, 0, 0, 1, 4'd5, 16'h00F0, 32'h500);
        #1;
        chk("t6_c1_addr", MemAddr, 32'h4F4);
        adv(); RST = 1'b1; #1;
        chk("t6_c2_addr", MemAddr, 32'h4F8);
        adv(); RST = 1'b0; #1;
        chk("t6_c3_busy", Busy, 0); chk("t6_c3_req", MemReq, 0);
        chk("t6_c3_we", RegWE, 0);
        adv(); #1;
        chk("t6_c4_busy", Busy, 0); chk("t6_r5", regs[5], 32'hBB);

        // LDMIA R0,{R15}: PC write path
        MemRD = 32'hDEAD;
        launch(1, 1, 0, 0, 4'd0, 16'h8000, 32'h600);
        #1;
        chk("t6_pc_addr", MemAddr, 32'h600); chk("t6_pcwe", PCWE, 1);
        chk("t6_pc_regwe", RegWE, 0); chk("t6_pc_wd", RegWD, 32'hDEAD);
        adv(); #1;
        chk("t6_pc_done", Done, 1); chk("t6_pc_pcwe_off", PCWE, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
